// File: rtl/beam_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | beam_scan_pkg                                                        |
// | Shared types, widths and the saturating magnitude helper.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package beam_scan_pkg;

    localparam int SEL_W     = 5;
    localparam int PCM_W_DEF = 19;
    localparam int ACC_W_DEF = 27;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_COMPARE = 3'd3,
        ST_FINISH  = 3'd4
    } scan_state_t;

    // The lone most-negative code has no positive twin, so it clips to full scale.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] x, input int width);
        logic [31:0] mag;
        mag = x[31] ? 32'(-x) : 32'(x);
        if (mag == (32'd1 << (width - 1))) begin
            mag = mag - 32'd1;
        end
        return mag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/beam_energy_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | beam_energy_acc                                                      |
// | Sums saturated magnitudes of beam samples over a dwell window.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module beam_energy_acc
    import beam_scan_pkg::*;
#(
    parameter int PCM_W = PCM_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    enable,
    input  logic signed [PCM_W-1:0] sample,
    output logic [ACC_W-1:0]        acc
);

    logic [31:0]      w_mag;
    logic [ACC_W-1:0] r_acc;

    assign w_mag = sat_abs(32'(sample), PCM_W);
    assign acc   = r_acc;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc <= '0;
        end else if (enable) begin
            r_acc <= r_acc + ACC_W'(w_mag);
        end
    end

endmodule
`default_nettype wire

// File: rtl/beam_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | beam_scan_ctrl                                                       |
// | Sweeps steering codes, measures beam energy, steers to the loudest.  |
// | Option macro: BEAM_SCAN_HYST_EN (12.5% switching hysteresis).        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module beam_scan_ctrl
    import beam_scan_pkg::*;
#(
    parameter int NUM_DIRS       = 4,
    parameter int SETTLE_SAMPLES = 32,
    parameter int DWELL_SAMPLES  = 256,
    parameter int PCM_W          = PCM_W_DEF,
    parameter int ACC_W          = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic signed [PCM_W-1:0] beam_sample,
    input  logic                    start,
    input  logic                    continuous,
    input  logic                    manual_en,
    input  logic [SEL_W-1:0]        manual_sel,
    output logic [SEL_W-1:0]        delay_select,
    output logic                    busy,
    output logic                    done,
    output logic [SEL_W-1:0]        best_dir,
    output logic [ACC_W-1:0]        best_energy
);

    localparam int CNT_MAX = (SETTLE_SAMPLES > DWELL_SAMPLES) ? SETTLE_SAMPLES : DWELL_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    scan_state_t      r_state;
    logic [SEL_W-1:0] r_dir;
    logic [SEL_W-1:0] r_run_dir;
    logic [ACC_W-1:0] r_run_best;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] w_acc;
    logic             w_take;
    logic [SEL_W-1:0] w_win_dir;
    logic [ACC_W-1:0] w_win_e;
    logic [SEL_W-1:0] w_new_dir;
    logic [ACC_W-1:0] w_new_e;

    // Accumulator is held clear throughout SETTLE so each dwell starts from zero.
    beam_energy_acc #(
        .PCM_W (PCM_W),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state == ST_SETTLE),
        .enable (!manual_en && (r_state == ST_MEASURE) && sample_valid),
        .sample (beam_sample),
        .acc    (w_acc)
    );

    assign w_take    = (r_dir == '0) || (w_acc > r_run_best);
    assign w_win_dir = w_take ? r_dir : r_run_dir;
    assign w_win_e   = w_take ? w_acc : r_run_best;

`ifdef BEAM_SCAN_HYST_EN
    logic [ACC_W-1:0] r_dir_e [NUM_DIRS];
    logic             r_have_best;
    logic [ACC_W-1:0] w_old_e;
    logic [ACC_W:0]   w_thresh;
    logic             w_switch;

    // Energy seen this sweep at the direction currently being steered to.
    always_comb begin
        w_old_e = '0;
        for (int i = 0; i < NUM_DIRS; i++) begin
            if (best_dir == SEL_W'(i)) begin
                w_old_e = r_dir_e[i];
            end
        end
        if (best_dir == r_dir) begin
            w_old_e = w_acc;
        end
    end

    assign w_thresh  = (ACC_W+1)'(best_energy) + (ACC_W+1)'(best_energy >> 3);
    assign w_switch  = !r_have_best || ((ACC_W+1)'(w_win_e) > w_thresh);
    assign w_new_dir = w_switch ? w_win_dir : best_dir;
    assign w_new_e   = w_switch ? w_win_e : w_old_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIRS; i++) begin
                r_dir_e[i] <= '0;
            end
            r_have_best <= 1'b0;
        end else if (!manual_en && (r_state == ST_COMPARE)) begin
            for (int i = 0; i < NUM_DIRS; i++) begin
                if (r_dir == SEL_W'(i)) begin
                    r_dir_e[i] <= w_acc;
                end
            end
            if (r_dir == SEL_W'(NUM_DIRS - 1)) begin
                r_have_best <= 1'b1;
            end
        end
    end
`else
    assign w_new_dir = w_win_dir;
    assign w_new_e   = w_win_e;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dir        <= '0;
            r_run_dir    <= '0;
            r_run_best   <= '0;
            r_cnt        <= '0;
            delay_select <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            best_dir     <= '0;
            best_energy  <= '0;
        end else begin
            done <= 1'b0;
            if (manual_en) begin
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                busy         <= 1'b0;
                delay_select <= manual_sel;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        delay_select <= best_dir;
                        if (start) begin
                            r_state      <= ST_SETTLE;
                            r_dir        <= '0;
                            r_cnt        <= '0;
                            delay_select <= '0;
                            busy         <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (sample_valid) begin
                            if (r_cnt == CNT_W'(SETTLE_SAMPLES - 1)) begin
                                r_cnt   <= '0;
                                r_state <= ST_MEASURE;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_MEASURE: begin
                        if (sample_valid) begin
                            if (r_cnt == CNT_W'(DWELL_SAMPLES - 1)) begin
                                r_cnt   <= '0;
                                r_state <= ST_COMPARE;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_COMPARE: begin
                        r_run_best <= w_win_e;
                        r_run_dir  <= w_win_dir;
                        // Publish on the last compare so done is high during FINISH.
                        if (r_dir == SEL_W'(NUM_DIRS - 1)) begin
                            r_state      <= ST_FINISH;
                            done         <= 1'b1;
                            best_dir     <= w_new_dir;
                            best_energy  <= w_new_e;
                            delay_select <= w_new_dir;
                        end else begin
                            r_state      <= ST_SETTLE;
                            r_dir        <= r_dir + SEL_W'(1);
                            delay_select <= r_dir + SEL_W'(1);
                        end
                    end
                    ST_FINISH: begin
                        if (continuous) begin
                            r_state      <= ST_SETTLE;
                            r_dir        <= '0;
                            r_cnt        <= '0;
                            delay_select <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_beam_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_beam_scan_ctrl                                                    |
// | Directed table plus hand sequences for the beam sweep controller.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_beam_scan_ctrl;

    localparam int NUM_DIRS = 4;
    localparam int SETTLE   = 2;
    localparam int DWELL    = 4;
    localparam int PCM_W    = 19;
    localparam int ACC_W    = 27;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    sample_valid;
    logic signed [PCM_W-1:0] beam_sample;
    logic                    start;
    logic                    continuous;
    logic                    manual_en;
    logic [4:0]              manual_sel;
    logic [4:0]              delay_select;
    logic                    busy;
    logic                    done;
    logic [4:0]              best_dir;
    logic [ACC_W-1:0]        best_energy;

    int n_cmp = 0;
    int n_bad = 0;
    int strobes;
    int dones;
    int busy_low;

    logic signed [PCM_W-1:0] amp [4];

    typedef struct {
        int a0;
        int a1;
        int a2;
        int a3;
        int dir;
        int energy;
    } vec_t;

    vec_t vecs [6];

    beam_scan_ctrl #(
        .NUM_DIRS       (NUM_DIRS),
        .SETTLE_SAMPLES (SETTLE),
        .DWELL_SAMPLES  (DWELL),
        .PCM_W          (PCM_W),
        .ACC_W          (ACC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .beam_sample  (beam_sample),
        .start        (start),
        .continuous   (continuous),
        .manual_en    (manual_en),
        .manual_sel   (manual_sel),
        .delay_select (delay_select),
        .busy         (busy),
        .done         (done),
        .best_dir     (best_dir),
        .best_energy  (best_energy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_amp(input int a0, input int a1, input int a2, input int a3);
        amp[0] = PCM_W'(a0);
        amp[1] = PCM_W'(a1);
        amp[2] = PCM_W'(a2);
        amp[3] = PCM_W'(a3);
    endtask

    task automatic set_vec(input int i, input int a0, input int a1, input int a2,
                           input int a3, input int dir, input int energy);
        vecs[i].a0     = a0;
        vecs[i].a1     = a1;
        vecs[i].a2     = a2;
        vecs[i].a3     = a3;
        vecs[i].dir    = dir;
        vecs[i].energy = energy;
    endtask

    // The sample source follows the steering code, like the real delay module.
    task automatic cyc(input bit v);
        sample_valid = v;
        beam_sample  = amp[delay_select[1:0]];
        if (v) strobes++;
        tick();
        if (done === 1'b1) dones++;
        if (busy !== 1'b1) busy_low++;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        start        = 1'b0;
        continuous   = 1'b0;
        manual_en    = 1'b0;
        manual_sel   = 5'd0;
        sample_valid = 1'b0;
        beam_sample  = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic run_to_done(input int target, input int budget);
        bit v;
        int c;
        int d0;
        v = 1'b1;
        c = 0;
        while (dones < target && c < budget) begin
            d0 = dones;
            cyc(v);
            c++;
            v = (dones != d0) ? 1'b0 : !v;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1'b0);
        start = 1'b0;
    endtask

    task automatic one_sweep(input string tag, input int exp_dir, input int exp_e);
        dones = 0;
        pulse_start();
        run_to_done(1, 200);
        cyc(1'b0);
        check({tag, "_done"}, 32'(dones), 32'd1);
        check({tag, "_best_dir"}, 32'(best_dir), 32'(exp_dir));
        check({tag, "_best_energy"}, 32'(best_energy), 32'(exp_e));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0,      10,     -50,      30,  50, 1, 200);
        set_vec(1,       0,       0, -262144,   0, 2, 1048572);
        set_vec(2,     100,     100,     100, 100, 0, 400);
        set_vec(3,      -5,       3,       7,  -8, 3, 32);
        set_vec(4,       0,       0,       0,   0, 0, 0);
        set_vec(5,  262143, -262143,       1,   0, 0, 1048572);
        set_amp(0, 0, 0, 0);

        // Reset and idle
        do_reset();
        dones = 0;
        repeat (20) cyc(1'b0);
        check("rst_delay_select", 32'(delay_select), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_count", 32'(dones), 32'd0);
        check("rst_best_dir", 32'(best_dir), 32'd0);
        check("rst_best_energy", 32'(best_energy), 32'd0);

        // Table of single sweeps, each from reset
        for (int i = 0; i < 6; i++) begin
            do_reset();
            set_amp(vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3);
            dones = 0;
            pulse_start();
            strobes  = 0;
            busy_low = 0;
            run_to_done(1, 200);
            check("tbl_strobes_to_done", 32'(strobes), 32'd24);
            check("tbl_busy_during", 32'(busy_low), 32'd0);
            repeat (6) cyc(1'b0);
            check("tbl_done_count", 32'(dones), 32'd1);
            check("tbl_best_dir", 32'(best_dir), 32'(vecs[i].dir));
            check("tbl_best_energy", 32'(best_energy), 32'(vecs[i].energy));
            check("tbl_sel_after", 32'(delay_select), 32'(vecs[i].dir));
            check("tbl_busy_after", 32'(busy), 32'd0);
        end

        // Continuous sweeps with an ignored start mid-sweep
        do_reset();
        set_amp(10, -50, 30, 50);
        continuous = 1'b1;
        dones = 0;
        pulse_start();
        busy_low = 0;
        strobes  = 0;
        run_to_done(1, 200);
        check("cont_strobes_1", 32'(strobes), 32'd24);
        strobes = 0;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        start = 1'b1;
        cyc(1'b1);
        start = 1'b0;
        cyc(1'b0);
        run_to_done(2, 200);
        check("cont_strobes_2", 32'(strobes), 32'd24);
        cyc(1'b0);
        cyc(1'b1);
        continuous = 1'b0;
        run_to_done(3, 200);
        check("cont_busy_held", 32'(busy_low), 32'd0);
        cyc(1'b0);
        check("cont_busy_end", 32'(busy), 32'd0);
        repeat (30) cyc(1'b0);
        check("cont_done_count", 32'(dones), 32'd3);
        check("cont_best_dir", 32'(best_dir), 32'd1);
        check("cont_best_energy", 32'(best_energy), 32'd200);

        // Manual override during MEASURE
        dones = 0;
        pulse_start();
        cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b1);
        manual_en  = 1'b1;
        manual_sel = 5'd7;
        cyc(1'b0);
        check("man_sel", 32'(delay_select), 32'd7);
        check("man_busy", 32'(busy), 32'd0);
        repeat (40) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        check("man_no_done", 32'(dones), 32'd0);
        check("man_best_dir", 32'(best_dir), 32'd1);
        check("man_best_energy", 32'(best_energy), 32'd200);
        check("man_sel_hold", 32'(delay_select), 32'd7);
        manual_en = 1'b0;
        cyc(1'b0);
        check("man_release_sel", 32'(delay_select), 32'd1);
        repeat (20) cyc(1'b0);
        check("man_release_done", 32'(dones), 32'd0);
        check("man_release_busy", 32'(busy), 32'd0);

        // Back-to-back sweeps with a marginally louder challenger
        do_reset();
        set_amp(0, 0, 100, 0);
        one_sweep("hy1", 2, 400);
        set_amp(0, 0, 100, 105);
`ifdef BEAM_SCAN_HYST_EN
        one_sweep("hy2", 2, 400);
`else
        one_sweep("hy2", 3, 420);
`endif
        set_amp(0, 0, 100, 200);
        one_sweep("hy3", 3, 800);

        // Reset landing in COMPARE
        set_amp(10, -50, 30, 50);
        dones = 0;
        pulse_start();
        repeat (5) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        cyc(1'b1);
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        check("rstc_delay_select", 32'(delay_select), 32'd0);
        check("rstc_busy", 32'(busy), 32'd0);
        check("rstc_done", 32'(done), 32'd0);
        check("rstc_best_dir", 32'(best_dir), 32'd0);
        check("rstc_best_energy", 32'(best_energy), 32'd0);
        repeat (10) cyc(1'b0);
        check("rstc_no_done", 32'(dones), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
